// File: rtl/adc_spi_reader_if.sv
// Host and SPI pin bundle for the serial ADC reader.
// The master side is the reader itself; the slave side is the host plus the ADC pins.
interface adc_spi_reader_if #(
  parameter int unsigned DATA_W = 12
);
  logic              start;
  logic [2:0]        channel_addr;
  logic              busy;
  logic              sample_valid;
  logic [DATA_W-1:0] sample;
  logic [2:0]        sample_channel;
  logic              spi_cs_n;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;

  modport master (
    input  start,
    input  channel_addr,
    input  spi_miso,
    output busy,
    output sample_valid,
    output sample,
    output sample_channel,
    output spi_cs_n,
    output spi_sclk,
    output spi_mosi
  );

  modport slave (
    output start,
    output channel_addr,
    output spi_miso,
    input  busy,
    input  sample_valid,
    input  sample,
    input  sample_channel,
    input  spi_cs_n,
    input  spi_sclk,
    input  spi_mosi
  );
endinterface

// File: rtl/adc_spi_reader.sv
// SPI master for the 8-channel 12-bit MegaWing ADC: one 16-SCLK frame per start,
// returning the sample tagged with the channel addressed in the previous frame.
module adc_spi_reader #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DATA_W  = 12
) (
  input logic               clk,
  input logic               reset,
  adc_spi_reader_if.master  bus
);

  localparam int unsigned CntW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [4:0]        half_q, half_d;
  logic [15:0]       tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [2:0]        addr_q, addr_d;
  logic [2:0]        prev_addr_q, prev_addr_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [2:0]        chan_q, chan_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              div_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      half_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      addr_q      <= '0;
      prev_addr_q <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      sample_q    <= '0;
      chan_q      <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      addr_q      <= addr_d;
      prev_addr_q <= prev_addr_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      sample_q    <= sample_d;
      chan_q      <= chan_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    addr_d      = addr_q;
    prev_addr_d = prev_addr_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    sample_d    = sample_q;
    chan_d      = chan_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    div_done    = (cnt_q == CntW'(CLK_DIV - 1));

    // One shared divider paces every non-idle state.
    if (state_q != StIdle) begin
      cnt_d = div_done ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          addr_d  = bus.channel_addr;
          tx_d    = {2'b00, bus.channel_addr, 11'b0};
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (div_done) begin
          half_d  = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (div_done) begin
          sclk_d = ~sclk_q;
          half_d = half_q + 5'd1;
          if (sclk_q) begin
            // The first falling edge keeps tx[15] on the line; later falls advance it.
            if (half_q != 5'd0) begin
              tx_d = {tx_q[14:0], 1'b0};
            end
          end else begin
            // Only the low DATA_W bits survive; the ADC's leading zeros shift out.
            rx_d = {rx_q[DATA_W-2:0], bus.spi_miso};
            if (half_q == 5'd31) begin
              state_d = StHold;
            end
          end
        end
      end
      StHold: begin
        if (div_done) begin
          cs_n_d      = 1'b1;
          valid_d     = 1'b1;
          sample_d    = rx_q;
          chan_d      = prev_addr_q;
          prev_addr_d = addr_q;
          tx_d        = '0;
          state_d     = StGap;
        end
      end
      StGap: begin
        if (div_done) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy           = busy_q;
  assign bus.sample_valid   = valid_q;
  assign bus.sample         = sample_q;
  assign bus.sample_channel = chan_q;
  assign bus.spi_cs_n       = cs_n_q;
  assign bus.spi_sclk       = sclk_q;
  assign bus.spi_mosi       = tx_q[15];

endmodule
